// File: rtl/writeback_commit_rob_pkg.sv
// Shared types for the writeback/commit stage.
// Register-address width is fixed by the ISA, so it lives here rather than as a parameter.
package writeback_commit_rob_pkg;

    localparam int unsigned reg_addr_bits = 5;

    typedef logic [reg_addr_bits-1:0] reg_addr_t;

endpackage

// File: rtl/writeback_commit_rob_if.sv
// Execute-to-writeback completion channels plus the complete and commit broadcasts.
// slave is the writeback stage; master is whatever drives the execute pipes.
interface writeback_commit_rob_if
    import writeback_commit_rob_pkg::*;
#(
    parameter int unsigned p_num_pipes    = 2,
    parameter int unsigned p_seq_num_bits = 5,
    parameter int unsigned p_addr_bits    = 32,
    parameter int unsigned p_data_bits    = 32
);
    logic [p_num_pipes-1:0]                     ex_val;
    logic [p_num_pipes-1:0]                     ex_rdy;
    logic [p_num_pipes-1:0][p_addr_bits-1:0]    ex_pc;
    logic [p_num_pipes-1:0][p_seq_num_bits-1:0] ex_seq_num;
    logic [p_num_pipes-1:0][reg_addr_bits-1:0]  ex_waddr;
    logic [p_num_pipes-1:0][p_data_bits-1:0]    ex_wdata;
    logic [p_num_pipes-1:0]                     ex_wen;

    logic                      complete_val;
    logic [p_seq_num_bits-1:0] complete_seq_num;
    reg_addr_t                 complete_waddr;
    logic [p_data_bits-1:0]    complete_wdata;
    logic                      complete_wen;

    logic                      commit_val;
    logic [p_addr_bits-1:0]    commit_pc;
    logic [p_seq_num_bits-1:0] commit_seq_num;
    reg_addr_t                 commit_waddr;
    logic [p_data_bits-1:0]    commit_wdata;
    logic                      commit_wen;

    modport master (
        output ex_val, ex_pc, ex_seq_num, ex_waddr, ex_wdata, ex_wen,
        input  ex_rdy,
        input  complete_val, complete_seq_num, complete_waddr, complete_wdata, complete_wen,
        input  commit_val, commit_pc, commit_seq_num, commit_waddr, commit_wdata, commit_wen
    );

    modport slave (
        input  ex_val, ex_pc, ex_seq_num, ex_waddr, ex_wdata, ex_wen,
        output ex_rdy,
        output complete_val, complete_seq_num, complete_waddr, complete_wdata, complete_wen,
        output commit_val, commit_pc, commit_seq_num, commit_waddr, commit_wdata, commit_wen
    );

endinterface

// File: rtl/writeback_commit_rob_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at ptr, ptr moves past the winner on a grant.
// Latency 0 (combinational grant); non-winning requesters simply see no grant and must hold.
module rr_arbiter #(
    parameter int unsigned p_num_req = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [p_num_req-1:0] req,
    output logic [p_num_req-1:0] gnt
);
    localparam int unsigned ptr_bits = (p_num_req > 1) ? $clog2(p_num_req) : 1;

    logic [ptr_bits-1:0] ptr;
    logic [ptr_bits-1:0] ptr_nxt;
    logic                found;

    function automatic logic [ptr_bits-1:0] after(input int i);
        return (i + 1 >= int'(p_num_req)) ? '0 : ptr_bits'(i + 1);
    endfunction

    // First pass searches ptr..N-1, second pass wraps around to 0..ptr-1.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        for (int i = 0; i < int'(p_num_req); i++) begin
            if (!found && req[i] && i >= int'(ptr)) begin
                gnt[i]  = 1'b1;
                found   = 1'b1;
                ptr_nxt = after(i);
            end
        end
        for (int i = 0; i < int'(p_num_req); i++) begin
            if (!found && req[i]) begin
                gnt[i]  = 1'b1;
                found   = 1'b1;
                ptr_nxt = after(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/writeback_commit_rob.sv
// Writeback/commit: arbitrates execute completions into a seq_num-indexed ROB, commits in order.
// Complete is same-cycle as accept, commit is 1 cycle later at the earliest; losing pipes hold val.
module writeback_commit_rob
    import writeback_commit_rob_pkg::*;
#(
    parameter int unsigned p_num_pipes   = 2,
    parameter int unsigned p_rob_entries = 32,
    parameter int unsigned p_addr_bits   = 32,
    parameter int unsigned p_data_bits   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    writeback_commit_rob_if.slave wb
);
    localparam int unsigned p_seq_num_bits = $clog2(p_rob_entries);

    typedef logic [p_seq_num_bits-1:0] seq_t;

    typedef struct packed {
        logic [p_addr_bits-1:0] pc;
        reg_addr_t              waddr;
        logic [p_data_bits-1:0] wdata;
        logic                   wen;
    } rob_entry_t;

    logic [p_num_pipes-1:0]   gnt;
    logic                     wr_en;
    seq_t                     wr_seq;
    rob_entry_t               wr_entry;
    int unsigned              wr_idx;

    rob_entry_t               rob [p_rob_entries];
    logic [p_rob_entries-1:0] valid;
    seq_t                     head;
    logic                     commit_fire;

    rr_arbiter #(.p_num_req(p_num_pipes)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (wb.ex_val),
        .gnt (gnt)
    );

    // The arbiter only grants requesting pipes, so any grant is a transfer.
    assign wb.ex_rdy = gnt;

    always_comb begin
        wr_en    = 1'b0;
        wr_seq   = '0;
        wr_entry = '0;
        wr_idx   = 0;
        for (int i = 0; i < int'(p_num_pipes); i++) begin
            if (gnt[i]) begin
                wr_en          = 1'b1;
                wr_idx         = i;
                wr_seq         = wb.ex_seq_num[i];
                wr_entry.pc    = wb.ex_pc[i];
                wr_entry.waddr = wb.ex_waddr[i];
                wr_entry.wdata = wb.ex_wdata[i];
                wr_entry.wen   = wb.ex_wen[i];
            end
        end
    end

    assign wb.complete_val     = wr_en;
    assign wb.complete_seq_num = wr_seq;
    assign wb.complete_waddr   = wr_entry.waddr;
    assign wb.complete_wdata   = wr_entry.wdata;
    assign wb.complete_wen     = wr_entry.wen;

    assign commit_fire       = valid[head];
    assign wb.commit_val     = commit_fire;
    assign wb.commit_pc      = rob[head].pc;
    assign wb.commit_seq_num = head;
    assign wb.commit_waddr   = rob[head].waddr;
    assign wb.commit_wdata   = rob[head].wdata;
    assign wb.commit_wen     = rob[head].wen;

    // Write and commit never target the same slot, so clear and set can both land this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            head  <= '0;
        end else begin
            if (commit_fire) begin
                valid[head] <= 1'b0;
                head        <= head + seq_t'(1);
            end
            if (wr_en) begin
                valid[wr_seq] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rob[wr_seq] <= wr_entry;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                assert (!valid[wr_seq])
                    else $error("rob slot %0d written while still valid", wr_seq);
            end
            for (int i = 0; i < int'(p_num_pipes); i++) begin
                for (int j = i + 1; j < int'(p_num_pipes); j++) begin
                    if (wb.ex_val[i] && wb.ex_val[j]) begin
                        assert (wb.ex_seq_num[i] != wb.ex_seq_num[j])
                            else $error("pipes %0d and %0d present the same seq_num", i, j);
                    end
                end
            end
        end
    end

    function automatic string trace();
        if (wr_en) begin
            return $sformatf("g=%0d head=%0d pc=%h", wr_idx, head, wb.commit_pc);
        end
        return $sformatf("g=- head=%0d pc=%h", head, wb.commit_pc);
    endfunction
`endif

endmodule
